// File: rtl/qcv_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : qcv_load_store_unit
// Brief    : qcv load/store unit. Single-request req/gnt/rvalid data-memory
//            master with byte enables, lane rotation and load extension.
//            Define QCV_LSU_MISALIGNED_EN to split word-crossing accesses into
//            two bus transactions; otherwise they complete with an error.
// Revision : 1.0 - initial release
// ============================================================================
module qcv_load_store_unit (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_wdata_i,
    input  logic [31:0] adder_result_ex_i,

    output logic        busy_o,
    output logic        lsu_resp_valid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        load_err_o,
    output logic        store_err_o,
    output logic [31:0] addr_last_o,

    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        WAIT_GNT      = 3'd1,
        WAIT_RVALID   = 3'd2
`ifdef QCV_LSU_MISALIGNED_EN
        ,
        WAIT_GNT_2    = 3'd3,
        WAIT_RVALID_2 = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [31:0] r_addr;
    logic [1:0]  r_type;
    logic        r_we;
    logic        r_sign_ext;
    logic [31:0] r_wdata;
`ifdef QCV_LSU_MISALIGNED_EN
    logic [31:0] r_rdata_lo;
    logic        r_err;
`endif

    logic [1:0]  w_off;
    logic [7:0]  w_size_mask;
    logic [7:0]  w_be_span;
    logic        w_split;
    logic [31:0] w_addr_lo;
    logic [31:0] w_addr_hi;
    logic [31:0] w_wdata_rot;
    logic [31:0] w_rd_lo;
    logic [31:0] w_rdata_al;
    logic [31:0] w_rdata_ext;
    logic        w_second;
    logic        w_err;
    logic        w_req;
    logic        w_resp;

    // ------------------------------------------------------------------------
    // Access geometry from the captured request
    // ------------------------------------------------------------------------
    assign w_off = r_addr[1:0];

    always_comb begin
        w_size_mask = 8'b0000_1111;
        case (r_type)
            2'b01:   w_size_mask = 8'b0000_0011;
            2'b10:   w_size_mask = 8'b0000_0001;
            default: w_size_mask = 8'b0000_1111;
        endcase
    end

    // Lower nibble covers the first word, upper nibble spills into the next.
    assign w_be_span = w_size_mask << w_off;
    assign w_split   = |w_be_span[7:4];
    assign w_addr_lo = {r_addr[31:2], 2'b00};
    assign w_addr_hi = w_addr_lo + 32'd4;

    // Store data rotated left into its byte lanes; the same word serves both
    // halves of a split access.
    always_comb begin
        w_wdata_rot = lsu_wdata_i;
        case (adder_result_ex_i[1:0])
            2'd1:    w_wdata_rot = {lsu_wdata_i[23:0], lsu_wdata_i[31:24]};
            2'd2:    w_wdata_rot = {lsu_wdata_i[15:0], lsu_wdata_i[31:16]};
            2'd3:    w_wdata_rot = {lsu_wdata_i[7:0],  lsu_wdata_i[31:8]};
            default: w_wdata_rot = lsu_wdata_i;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load data: rotate right and merge the two parts, then extend
    // ------------------------------------------------------------------------
`ifdef QCV_LSU_MISALIGNED_EN
    assign w_rd_lo = (r_state == WAIT_RVALID_2) ? r_rdata_lo : data_rdata_i;
`else
    assign w_rd_lo = data_rdata_i;
`endif

    always_comb begin
        w_rdata_al = w_rd_lo;
        case (w_off)
            2'd1:    w_rdata_al = {data_rdata_i[7:0],  w_rd_lo[31:8]};
            2'd2:    w_rdata_al = {data_rdata_i[15:0], w_rd_lo[31:16]};
            2'd3:    w_rdata_al = {data_rdata_i[23:0], w_rd_lo[31:24]};
            default: w_rdata_al = w_rd_lo;
        endcase
    end

    always_comb begin
        w_rdata_ext = w_rdata_al;
        case (r_type)
            2'b01:   w_rdata_ext = {{16{r_sign_ext & w_rdata_al[15]}}, w_rdata_al[15:0]};
            2'b10:   w_rdata_ext = {{24{r_sign_ext & w_rdata_al[7]}},  w_rdata_al[7:0]};
            default: w_rdata_ext = w_rdata_al;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_type     <= '0;
            r_we       <= 1'b0;
            r_sign_ext <= 1'b0;
            r_wdata    <= '0;
`ifdef QCV_LSU_MISALIGNED_EN
            r_rdata_lo <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            if (r_state == IDLE && lsu_req_i) begin
                r_addr     <= adder_result_ex_i;
                r_type     <= lsu_type_i;
                r_we       <= lsu_we_i;
                r_sign_ext <= lsu_sign_ext_i;
                r_wdata    <= w_wdata_rot;
            end
`ifdef QCV_LSU_MISALIGNED_EN
            if (r_state == WAIT_RVALID && data_rvalid_i) begin
                r_rdata_lo <= data_rdata_i;
                r_err      <= data_err_i;
            end
`endif
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_req      = 1'b0;
        w_resp     = 1'b0;
        w_second   = 1'b0;
        w_err      = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsu_req_i) begin
                    w_state_nx = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
`ifdef QCV_LSU_MISALIGNED_EN
                w_req = 1'b1;
                if (data_gnt_i) begin
                    w_state_nx = WAIT_RVALID;
                end
`else
                // Boundary-crossing access is refused without touching the bus.
                if (w_split) begin
                    w_resp     = 1'b1;
                    w_err      = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_req = 1'b1;
                    if (data_gnt_i) begin
                        w_state_nx = WAIT_RVALID;
                    end
                end
`endif
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
`ifdef QCV_LSU_MISALIGNED_EN
                    if (w_split) begin
                        w_state_nx = WAIT_GNT_2;
                    end else begin
                        w_resp     = 1'b1;
                        w_err      = data_err_i;
                        w_state_nx = IDLE;
                    end
`else
                    w_resp     = 1'b1;
                    w_err      = data_err_i;
                    w_state_nx = IDLE;
`endif
                end
            end
`ifdef QCV_LSU_MISALIGNED_EN
            WAIT_GNT_2: begin
                w_req    = 1'b1;
                w_second = 1'b1;
                if (data_gnt_i) begin
                    w_state_nx = WAIT_RVALID_2;
                end
            end
            WAIT_RVALID_2: begin
                w_second = 1'b1;
                if (data_rvalid_i) begin
                    w_resp     = 1'b1;
                    w_err      = r_err | data_err_i;
                    w_state_nx = IDLE;
                end
            end
`endif
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output drive; bus fields are zero whenever no request is outstanding
    // ------------------------------------------------------------------------
    assign busy_o           = (r_state != IDLE);
    assign addr_last_o      = r_addr;
    assign lsu_resp_valid_o = w_resp;
    assign lsu_rdata_o      = (w_resp && !r_we) ? w_rdata_ext : 32'd0;
    assign load_err_o       = w_resp & w_err & ~r_we;
    assign store_err_o      = w_resp & w_err & r_we;

    assign data_req_o   = w_req;
    assign data_addr_o  = w_req ? (w_second ? w_addr_hi : w_addr_lo) : 32'd0;
    assign data_be_o    = w_req ? (w_second ? w_be_span[7:4] : w_be_span[3:0]) : 4'd0;
    assign data_we_o    = w_req & r_we;
    assign data_wdata_o = w_req ? r_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_qcv_load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized self-checking bench for qcv_load_store_unit; expected bus images
// and load results are rebuilt byte by byte from the access address and size.
module tb_qcv_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [1:0]  lsu_type = 2'd0;
    logic        lsu_sign_ext = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [31:0] adder_result = '0;
    logic        busy;
    logic        resp_valid;
    logic [31:0] lsu_rdata;
    logic        load_err;
    logic        store_err;
    logic [31:0] addr_last;
    logic        data_req;
    logic        data_gnt = 1'b0;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_rvalid = 1'b0;
    logic [31:0] data_rdata = '0;
    logic        data_err = 1'b0;

    int checks = 0;
    int errors = 0;

    qcv_load_store_unit dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .lsu_req_i         (lsu_req),
        .lsu_we_i          (lsu_we),
        .lsu_type_i        (lsu_type),
        .lsu_sign_ext_i    (lsu_sign_ext),
        .lsu_wdata_i       (lsu_wdata),
        .adder_result_ex_i (adder_result),
        .busy_o            (busy),
        .lsu_resp_valid_o  (resp_valid),
        .lsu_rdata_o       (lsu_rdata),
        .load_err_o        (load_err),
        .store_err_o       (store_err),
        .addr_last_o       (addr_last),
        .data_req_o        (data_req),
        .data_gnt_i        (data_gnt),
        .data_addr_o       (data_addr),
        .data_we_o         (data_we),
        .data_be_o         (data_be),
        .data_wdata_o      (data_wdata),
        .data_rvalid_i     (data_rvalid),
        .data_rdata_i      (data_rdata),
        .data_err_i        (data_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int access_size(input logic [1:0] t);
        if (t == 2'b01) return 2;
        if (t == 2'b10) return 1;
        return 4;
    endfunction

    // Request-side noise while busy: must never be accepted.
    task automatic junk_inputs();
        lsu_req      = 1'($urandom % 2);
        lsu_we       = 1'($urandom % 2);
        lsu_type     = 2'($urandom % 4);
        lsu_sign_ext = 1'($urandom % 2);
        lsu_wdata    = $urandom;
        adder_result = $urandom;
    endtask

    task automatic run_access(input logic we, input logic [1:0] typ, input logic sx,
                              input logic [31:0] wd, input logic [31:0] addr,
                              input logic [31:0] rd0, input logic [31:0] rd1,
                              input logic e0, input logic e1,
                              input int gd, input int rvd);
        int          off;
        int          sz;
        int          nparts;
        logic        split;
        logic [3:0]  exp_be [2];
        logic [31:0] exp_wd [2];
        logic [31:0] exp_mask [2];
        logic [31:0] rd [2];
        logic        er [2];
        logic [31:0] raw;
        logic [31:0] exp_rd;
        logic        exp_err;

        off = int'(addr[1:0]);
        sz  = access_size(typ);
        split = (off + sz) > 4;
        nparts = split ? 2 : 1;
        rd[0] = rd0; rd[1] = rd1;
        er[0] = e0;  er[1] = e1;
        for (int p = 0; p < 2; p++) begin
            exp_be[p] = '0; exp_wd[p] = '0; exp_mask[p] = '0;
        end
        raw = '0;
        for (int i = 0; i < sz; i++) begin
            int pos;
            int p;
            int lane;
            pos  = off + i;
            p    = pos / 4;
            lane = pos % 4;
            exp_be[p][lane]            = 1'b1;
            exp_mask[p][lane*8 +: 8]   = 8'hFF;
            exp_wd[p][lane*8 +: 8]     = wd[i*8 +: 8];
            raw[i*8 +: 8]              = rd[p][lane*8 +: 8];
        end
        if (sz == 1)      exp_rd = sx ? {{24{raw[7]}}, raw[7:0]}   : {24'd0, raw[7:0]};
        else if (sz == 2) exp_rd = sx ? {{16{raw[15]}}, raw[15:0]} : {16'd0, raw[15:0]};
        else              exp_rd = raw;
        exp_err = e0 | (split & e1);

        @(negedge clk);
        lsu_req = 1'b1; lsu_we = we; lsu_type = typ; lsu_sign_ext = sx;
        lsu_wdata = wd; adder_result = addr;
        #1;
        check_value("busy_before_accept", 32'(busy), 32'd0);
        @(negedge clk);
        junk_inputs();
        #1;
        check_value("busy_after_accept", 32'(busy), 32'd1);
        check_value("addr_last", addr_last, addr);

`ifndef QCV_LSU_MISALIGNED_EN
        if (split) begin
            check_value("mis_resp", 32'(resp_valid), 32'd1);
            check_value("mis_no_req", 32'(data_req), 32'd0);
            check_value("mis_load_err", 32'(load_err), 32'(!we));
            check_value("mis_store_err", 32'(store_err), 32'(we));
            @(negedge clk);
            lsu_req = 1'b0;
            #1;
            check_value("mis_idle", 32'(busy), 32'd0);
            return;
        end
`endif

        for (int p = 0; p < nparts; p++) begin
            for (int c = 0; c <= gd; c++) begin
                check_value("req", 32'(data_req), 32'd1);
                check_value("resp_early", 32'(resp_valid), 32'd0);
                check_value("addr", data_addr, {addr[31:2], 2'b00} + 32'(4 * p));
                check_value("be", 32'(data_be), 32'(exp_be[p]));
                check_value("we", 32'(data_we), 32'(we));
                if (we) check_value("wdata", data_wdata & exp_mask[p], exp_wd[p]);
                if (c == gd) begin
                    data_rvalid = 1'b0;
                    data_gnt = 1'b1;
                end else begin
                    data_rvalid = ($urandom % 4) == 0;
                    data_err = 1'b1;
                end
                @(negedge clk);
                data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0;
                junk_inputs();
                #1;
            end
            for (int c = 0; c < rvd; c++) begin
                check_value("req_in_rvalid_wait", 32'(data_req), 32'd0);
                check_value("resp_before_rvalid", 32'(resp_valid), 32'd0);
                @(negedge clk);
                junk_inputs();
                #1;
            end
            data_rvalid = 1'b1; data_rdata = rd[p]; data_err = er[p];
            #1;
            if (p == nparts - 1) begin
                check_value("resp", 32'(resp_valid), 32'd1);
                check_value("busy_in_resp", 32'(busy), 32'd1);
                check_value("load_err", 32'(load_err), 32'(exp_err & !we));
                check_value("store_err", 32'(store_err), 32'(exp_err & we));
                if (!we) check_value("rdata", lsu_rdata, exp_rd);
                check_value("addr_last_resp", addr_last, addr);
            end else begin
                check_value("resp_mid_split", 32'(resp_valid), 32'd0);
            end
            @(negedge clk);
            data_rvalid = 1'b0; data_err = 1'b0; data_rdata = $urandom;
            if (p < nparts - 1) junk_inputs();
            #1;
        end
        lsu_req = 1'b0;
        check_value("idle_after_resp", 32'(busy), 32'd0);
        check_value("no_resp_after", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_req", 32'(data_req), 32'd0);
        check_value("rst_addr_last", addr_last, 32'd0);
        check_value("rst_resp", 32'(resp_valid), 32'd0);
        check_value("rst_be", 32'(data_be), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_access(1'b0, 2'b00, 1'b0, 32'd0, 32'h0000_0100, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b10, 1'b1, 32'd0, 32'h0000_0203, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 0, 0);
        run_access(1'b0, 2'b10, 1'b0, 32'd0, 32'h0000_0203, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 0, 1);
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_ABCD, 32'h0000_0102, 32'd0, 32'd0, 1'b0, 1'b0, 1, 0);
        run_access(1'b0, 2'b00, 1'b0, 32'd0, 32'h0FFF_FFFE, 32'h1122_5566, 32'h7788_3344, 1'b0, 1'b0, 0, 0);
        run_access(1'b1, 2'b00, 1'b0, 32'hCAFE_F00D, 32'h0000_0300, 32'd0, 32'd0, 1'b1, 1'b0, 3, 1);
        run_access(1'b0, 2'b11, 1'b1, 32'd0, 32'hFFFF_FFFD, 32'hA1B2_C3D4, 32'hE5F6_0718, 1'b0, 1'b1, 1, 2);
        run_access(1'b1, 2'b01, 1'b0, 32'h0000_1234, 32'h0000_0503, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0);

        // Reset while waiting for rvalid, then a stray rvalid
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_type = 2'b00; adder_result = 32'h0000_0400;
        @(negedge clk);
        lsu_req = 1'b0;
        data_gnt = 1'b1;
        @(negedge clk);
        data_gnt = 1'b0;
        #1;
        check_value("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_value("async_rst_busy", 32'(busy), 32'd0);
        check_value("async_rst_req", 32'(data_req), 32'd0);
        check_value("async_rst_addr_last", addr_last, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        data_rvalid = 1'b1; data_rdata = 32'h5555_AAAA;
        #1;
        check_value("stray_rvalid_resp", 32'(resp_valid), 32'd0);
        check_value("stray_rvalid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        data_rvalid = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 250; n++) begin
            run_access(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2), $urandom, $urandom,
                       $urandom, $urandom, ($urandom % 6) == 0, ($urandom % 6) == 0,
                       int'($urandom % 4), int'($urandom % 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
